// File: rtl/loop_filter_mavg.sv
// loop_filter_mavg: moving-average loop filter for carrier/timing recovery.
// Keeps a running sum over a power-of-two window (N = 2**win_sel, clamped to
// 2**MAX_LOG2) of valid-qualified phase-detector samples. Outputs the raw sum,
// the shift-normalised average and a window-fill flag.
// Optional macro LF_INTEGRATOR_EN adds a saturating integrator on the average.
// Without that macro, integ_out is tied to zero.
module loop_filter_mavg #(
  parameter int DATA_W   = 17,
  parameter int MAX_LOG2 = 6,
  parameter int SUM_W    = DATA_W + MAX_LOG2,
  parameter int KI_SHIFT = 4,
  parameter int ACC_W    = 24
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  input  logic signed [DATA_W-1:0]           pd,
  input  logic [$clog2(MAX_LOG2+1)-1:0]      win_sel,
  input  logic                               clear,
  output logic signed [SUM_W-1:0]            sum_out,
  output logic signed [DATA_W-1:0]           avg_out,
  output logic                               out_valid,
  output logic                               filled,
  output logic signed [ACC_W-1:0]            integ_out
);

  localparam int DEPTH = 2 ** MAX_LOG2;
  localparam int WS_W  = $clog2(MAX_LOG2 + 1);
  localparam int CNT_W = MAX_LOG2 + 1;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [MAX_LOG2-1:0]      wr_ptr;
  logic [MAX_LOG2-1:0]      rd_ptr;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_next;
  logic [CNT_W-1:0]         n_cur;
  logic [WS_W-1:0]          win_q;
  logic [WS_W-1:0]          win_eff;
  logic                     flush;
  logic                     accept;
  logic                     full;
  logic signed [SUM_W-1:0]  oldest_ext;
  logic signed [SUM_W-1:0]  sum_next;
  logic signed [SUM_W-1:0]  sum_sh;
  logic signed [DATA_W-1:0] avg_next;

  // Next-state datapath: clamp window, detect flush, compute the new sum/average.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    win_eff    = (win_sel > WS_W'(MAX_LOG2)) ? WS_W'(MAX_LOG2) : win_sel;
    flush      = clear || (win_eff != win_q);
    accept     = in_valid && !flush;
    n_cur      = CNT_W'(1) << win_q;
    full       = (cnt == n_cur);
    // For the maximum window the subtraction wraps to wr_ptr itself, which is
    // exactly the slot written DEPTH samples ago.
    rd_ptr     = wr_ptr - n_cur[MAX_LOG2-1:0];
    oldest_ext = full ? SUM_W'(mem[rd_ptr]) : SUM_W'(0);
    sum_next   = sum_out + SUM_W'(pd) - oldest_ext;
    sum_sh     = sum_next >>> win_q;
    avg_next   = sum_sh[DATA_W-1:0];
    cnt_next   = full ? cnt : cnt + 1'b1;
  end

  // Sample history; stale entries after a flush are masked by cnt.
  // NOTE: the buffer has no reset so it can map onto RAM; cnt gates its contents.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= pd;
  end

  // Filter state: flush has priority, otherwise update on each accepted sample.
  // NOTE: all sequential state uses non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_out   <= '0;
      avg_out   <= '0;
      out_valid <= 1'b0;
      filled    <= 1'b0;
      wr_ptr    <= '0;
      cnt       <= '0;
      win_q     <= '0;
    end else begin
      win_q     <= win_eff;
      out_valid <= 1'b0;
      if (flush) begin
        sum_out <= '0;
        avg_out <= '0;
        cnt     <= '0;
        filled  <= 1'b0;
      end else if (accept) begin
        sum_out   <= sum_next;
        avg_out   <= avg_next;
        cnt       <= cnt_next;
        filled    <= (cnt_next == n_cur);
        wr_ptr    <= wr_ptr + 1'b1;
        out_valid <= 1'b1;
      end
    end
  end

`ifdef LF_INTEGRATOR_EN
  localparam logic signed [ACC_W:0] ACC_MAX = (ACC_W+1)'(2 ** (ACC_W - 1) - 1);
  localparam logic signed [ACC_W:0] ACC_MIN = -ACC_MAX;

  logic signed [ACC_W:0] integ_inc;
  logic signed [ACC_W:0] integ_sum;
  logic signed [ACC_W-1:0] integ_sat;

  // Integrator step: add the scaled new average with symmetric saturation.
  always_comb begin
    integ_inc = avg_next >>> KI_SHIFT;
    integ_sum = (ACC_W+1)'(integ_out) + integ_inc;
    if (integ_sum > ACC_MAX)      integ_sat = ACC_MAX[ACC_W-1:0];
    else if (integ_sum < ACC_MIN) integ_sat = ACC_MIN[ACC_W-1:0];
    else                          integ_sat = integ_sum[ACC_W-1:0];
  end

  // Integrator register: cleared by reset and clear, kept across window changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      integ_out <= '0;
    else if (clear)  integ_out <= '0;
    else if (accept) integ_out <= integ_sat;
  end
`else
  localparam int unused_ki_shift = KI_SHIFT;
  assign integ_out = '0;
`endif

endmodule

// File: tb/tb_loop_filter_mavg.sv
// Directed testbench for loop_filter_mavg (default build, integrator disabled).
module tb_loop_filter_mavg;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [16:0] pd;
  logic [2:0]         win_sel;
  logic               clear;
  logic signed [22:0] sum_out;
  logic signed [16:0] avg_out;
  logic               out_valid;
  logic               filled;
  logic signed [23:0] integ_out;

  int errors = 0;
  int checks = 0;

  loop_filter_mavg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .pd        (pd),
    .win_sel   (win_sel),
    .clear     (clear),
    .sum_out   (sum_out),
    .avg_out   (avg_out),
    .out_valid (out_valid),
    .filled    (filled),
    .integ_out (integ_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given sample; returns 1 time unit after the edge.
  task automatic step(input logic v, input int d);
    in_valid = v;
    pd       = 17'(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sum"},    sum_out,   0);
    check({tag, "_avg"},    avg_out,   0);
    check({tag, "_valid"},  out_valid, 0);
    check({tag, "_filled"}, filled,    0);
    check({tag, "_integ"},  integ_out, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    pd       = '0;
    win_sel  = 3'd2;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Reset mid-stream, N=4: first cycle flushes (window 0 -> 2).
    step(0, 0);
    for (int k = 1; k <= 3; k++) step(1, 100);
    check("pre_rst_sum", sum_out, 300);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    #3 rst_n = 1'b1;

    // Constant fill, N=8.
    win_sel = 3'd3;
    step(0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(1, 1000);
      check($sformatf("fill_sum%0d", k), sum_out, k * 1000);
      check($sformatf("fill_valid%0d", k), out_valid, 1);
      check($sformatf("fill_filled%0d", k), filled, (k == 8) ? 1 : 0);
    end
    for (int k = 0; k < 2; k++) begin
      step(1, 1000);
      check("steady_sum", sum_out, 8000);
      check("steady_avg", avg_out, 1000);
    end
    step(0, 0);
    check("idle_valid", out_valid, 0);
    check("idle_sum", sum_out, 8000);
    check("idle_filled", filled, 1);

    // Window change to N=2 with a sample in the flush cycle (dropped).
    win_sel = 3'd1;
    step(1, 5);
    check("wchg_sum", sum_out, 0);
    check("wchg_avg", avg_out, 0);
    check("wchg_filled", filled, 0);
    check("wchg_valid", out_valid, 0);
    check("wchg_integ", integ_out, 0);
    step(1, 7);
    check("wchg_s1", sum_out, 7);
    check("wchg_f1", filled, 0);
    step(1, 7);
    check("wchg_s2", sum_out, 14);
    check("wchg_a2", avg_out, 7);
    check("wchg_f2", filled, 1);

    // Sliding window, N=4.
    win_sel = 3'd2;
    step(0, 0);
    begin
      int samp[5] = '{1, 2, 3, 4, 10};
      int sums[5] = '{1, 3, 6, 10, 19};
      for (int k = 0; k < 5; k++) begin
        step(1, samp[k]);
        check($sformatf("slide_sum%0d", k), sum_out, sums[k]);
      end
    end
    check("slide_avg", avg_out, 4);
    check("slide_filled", filled, 1);

    // Explicit clear, then negative floor behaviour, N=4.
    clear = 1'b1;
    step(0, 0);
    clear = 1'b0;
    check("clr_sum", sum_out, 0);
    check("clr_filled", filled, 0);
    for (int k = 0; k < 4; k++) step(1, -3);
    check("neg_sum", sum_out, -12);
    check("neg_avg", avg_out, -3);
    step(1, -2);
    check("floor_sum", sum_out, -11);
    check("floor_avg", avg_out, -3);

    // Gapped valid, N=2.
    win_sel = 3'd1;
    step(0, 0);
    step(1, 50);
    check("gap_v1", out_valid, 1);
    check("gap_s1", sum_out, 50);
    step(0, 99);
    check("gap_idle_v", out_valid, 0);
    check("gap_idle_s", sum_out, 50);
    step(0, 99);
    check("gap_idle2_s", sum_out, 50);
    step(1, 70);
    check("gap_v2", out_valid, 1);
    check("gap_s2", sum_out, 120);

    // clear wins over in_valid.
    clear = 1'b1;
    step(1, 9);
    clear = 1'b0;
    check("clrpri_sum", sum_out, 0);
    check("clrpri_valid", out_valid, 0);

    // Out-of-range window clamps to N=64.
    win_sel = 3'd7;
    step(0, 0);
    step(1, 640);
    check("clamp_sum", sum_out, 640);
    check("clamp_avg", avg_out, 10);
    check("clamp_filled", filled, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
